// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the M-extension datapath.
// Holds widths, funct3 codes and muldiv FSM states.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// acc holds {hi, lo}: product/multiplier or remainder/quotient.
module muldiv_step
  import rv32_pkg::*;
(
  input  logic                is_div,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     operand,
  output logic [2*XLEN-1:0]   acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            no_borrow;
  logic [XLEN-1:0] rem_next;

  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]}
        + (acc[0] ? {1'b0, operand} : '0);
    shifted = acc[2*XLEN-1:XLEN-1];
    // 33-bit trial subtract; a set top bit always clears the divisor
    trial = {1'b0, shifted[XLEN-1:0]} - {1'b0, operand};
    no_borrow = shifted[XLEN] | ~trial[XLEN];
    rem_next = no_borrow ? trial[XLEN-1:0]
                         : shifted[XLEN-1:0];
    if (is_div)
      acc_next = {rem_next, acc[XLEN-2:0], no_borrow};
    else
      acc_next = {sum, acc[XLEN-1:1]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, fixed 34-cycle latency.
// Feeds the register file write port with result/rd/enable.
module muldiv_unit
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_en
);

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   step_op;
  logic [XLEN-1:0]   a_raw;
  logic              neg;
  logic              div_zero;
  logic              ovf;

  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] abs_a, abs_b;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_CALC;
      ST_CALC:
        if (cnt == CNT_W'(XLEN-1))
          state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand magnitudes and result sign, captured at issue
  always_comb begin
    sgn_a = operand_a[XLEN-1] &
            (funct3 == F3_MULH || funct3 == F3_MULHSU ||
             funct3 == F3_DIV  || funct3 == F3_REM);
    sgn_b = operand_b[XLEN-1] &
            (funct3 == F3_MULH || funct3 == F3_DIV ||
             funct3 == F3_REM);
    abs_a = sgn_a ? -operand_a : operand_a;
    abs_b = sgn_b ? -operand_b : operand_b;
  end

  muldiv_step u_step (
    .is_div   (op[2]),
    .acc      (acc),
    .operand  (step_op),
    .acc_next (acc_next)
  );

  always_comb begin
    prod_fix = neg ? -acc : acc;
    quo_fix  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg ? -acc[2*XLEN-1:XLEN]
                   : acc[2*XLEN-1:XLEN];
    fix_res  = '0;
    unique case (1'b1)
      op == F3_MUL:  fix_res = prod_fix[XLEN-1:0];
      !op[2] && op != F3_MUL:
        fix_res = prod_fix[2*XLEN-1:XLEN];
      op[2] && !op[1]: fix_res = quo_fix;
      op[2] && op[1]:  fix_res = rem_fix;
      default:         fix_res = '0;
    endcase
    if (op[2] && div_zero)
      fix_res = op[1] ? a_raw : '1;
    else if (ovf && (op == F3_DIV || op == F3_REM))
      fix_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      op         <= '0;
      rd         <= '0;
      acc        <= '0;
      step_op    <= '0;
      a_raw      <= '0;
      neg        <= 1'b0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
      result     <= '0;
      wb_rd_addr <= '0;
      done       <= 1'b0;
      wb_en      <= 1'b0;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
      unique case (state)
        ST_IDLE: if (start) begin
          op       <= funct3;
          rd       <= rd_addr;
          cnt      <= '0;
          a_raw    <= operand_a;
          neg      <= (funct3 == F3_REM) ? sgn_a
                                         : (sgn_a ^ sgn_b);
          div_zero <= (operand_b == '0);
          ovf      <= (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (operand_b == '1);
          if (funct3[2]) begin
            acc     <= {{XLEN{1'b0}}, abs_a};
            step_op <= abs_b;
          end else begin
            acc     <= {{XLEN{1'b0}}, abs_b};
            step_op <= abs_a;
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
        ST_FIX: begin
          result     <= fix_res;
          wb_rd_addr <= rd;
          done       <= 1'b1;
          wb_en      <= (rd != 5'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus
// randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  rd_addr;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  wb_rd_addr;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct3     (funct3),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .rd_addr    (rd_addr),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .wb_rd_addr (wb_rd_addr),
    .wb_en      (wb_en)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(
    input logic [2:0] f3,
    input logic [31:0] a,
    input logic [31:0] b);
    int sa32, sb32;
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    logic ov;
    sa32 = a;
    sb32 = b;
    sa = sa32;
    sb = sb32;
    ua = {32'b0, a};
    ub = {32'b0, b};
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin
        p = sa * longint'(ub);
        return p[63:32];
      end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        return 32'(sa32 / sb32);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        return 32'(sa32 % sb32);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at #1 after a posedge; start is sampled at the next edge
  task automatic issue(input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd);
    funct3    = f3;
    operand_a = a;
    operand_b = b;
    rd_addr   = rd;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    funct3    = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    rd_addr   = 5'($urandom);
  endtask

  // lat counts cycles with the issue cycle as 1
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp);
    int lat;
    issue(f3, a, b, rd);
    wait_done(1, lat);
    check({tag, "_lat"}, lat, 34);
    check({tag, "_res"}, result, exp);
    check({tag, "_rd"}, wb_rd_addr, rd);
    check({tag, "_wben"}, wb_en, rd != 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int lat, d0;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;

    reset = 1'b1;
    start = 1'b0;
    funct3 = '0;
    operand_a = '0;
    operand_b = '0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    check("rst_wben", wb_en, 0);
    check("rst_rd", wb_rd_addr, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mul", 3'd0, 32'd7, -32'sd3, 5'd5, 32'hFFFF_FFEB);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,
           32'h4000_0000);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
           32'hFFFF_FFFE);
    run_op("div", 3'd4, -32'sd20, 32'd3, 5'd3, 32'hFFFF_FFFA);
    run_op("rem", 3'd6, -32'sd20, 32'd3, 5'd4, 32'hFFFF_FFFE);
    run_op("divu", 3'd5, 32'd24, 32'd8, 5'd6, 32'd3);
    run_op("remu", 3'd7, 32'd19, 32'd4, 5'd7, 32'd3);
    run_op("div0", 3'd4, 32'd12, 32'd0, 5'd8, 32'hFFFF_FFFF);
    run_op("remu0", 3'd7, 32'd12, 32'd0, 5'd9, 32'd12);
    run_op("divov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10,
           32'h8000_0000);
    run_op("remov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
           32'h0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12,
           32'hFFFF_FFFF);
    run_op("rd0", 3'd0, 32'd6, 32'd7, 5'd0, 32'd42);

    // start while busy must not disturb the running op
    issue(3'd4, 32'd100, 32'd7, 5'd13);
    repeat (9) @(posedge clk);
    #1;
    funct3 = 3'd0;
    operand_a = 32'd3;
    operand_b = 32'd3;
    rd_addr = 5'd14;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(11, lat);
    check("busy_start_lat", lat, 34);
    check("busy_start_res", result, 14);
    check("busy_start_rd", wb_rd_addr, 13);
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("busy_start_ndone", done_cnt - d0, 1);

    // back-to-back: second op issued in the done cycle
    run_op("b2b_a", 3'd5, 32'd1000, 32'd10, 5'd15, 32'd100);
    run_op("b2b_b", 3'd0, 32'd11, 32'd12, 5'd16, 32'd132);

    // reset mid-operation
    issue(3'd4, 32'd500, 32'd5, 5'd17);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_res", result, 0);
    check("mrst_wben", wb_en, 0);
    check("mrst_rd", wb_rd_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (45) @(posedge clk);
    #1;
    check("mrst_ndone", done_cnt - d0, 0);

    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 15));
        4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      rd = 5'($urandom);
      run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, rd,
             ref_model(f3, a, b));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
